alu_mul_seq: RTL and testbench
==============================

Name: alu_mul_seq

Overview:
- Multi-cycle unsigned 16x16->32 multiplier built on the shared 16-bit combinational ALU.
- It drives the ALU operand/select inputs and consumes its result and flag outputs, one bit per clock (shift-and-add).
- It sits beside the ALU in the execute stage; the core issues a multiply with START and waits for DONE.
- While this block is idle it parks the ALU in the no-op select so the datapath mux can hand the ALU to other users.

Parameters:
- WIDTH, 16, operand width; must equal ALU data width (only 16 is supported).
- CNT_W, 5, iteration counter width; must be at least clog2(WIDTH)+1.

Ports:
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous active-low reset
- START  input  1  request a multiply; sampled only when READY=1
- ABORT  input  1  synchronous cancel of the operation in flight
- MCAND  input  16  multiplicand, latched on accepted START
- MPLIER  input  16  multiplier, latched on accepted START
- READY  output  1  high in IDLE only
- BUSY  output  1  high in RUN and FIN
- DONE  output  1  one-cycle pulse, PRODUCT valid
- PRODUCT  output  32  last completed product, held until next completion
- ALU_A  output  16  to ALU DATA_A
- ALU_B  output  16  to ALU DATA_B
- ALU_SEL  output  4  to ALU S_ALU
- ALU_RES  input  16  from ALU ALU_OUT
- ALU_FLAG  input  4  from ALU FLAG_OUT, ordered {S,Z,C,V}; C = bit 1

Behaviour:
- Single clock domain (CLK); asynchronous active-low reset RST_N.
- Reset values: state=IDLE; READY=1; BUSY=0; DONE=0; PRODUCT=0; ALU_A=0; ALU_B=0; ALU_SEL=4'b1111; internal P_HI, P_LO, MC and CNT all 0.
- Reset asserted mid-operation discards the operation immediately; no DONE is produced.
- State IDLE:
  - ALU_SEL=1111 (no-op); ALU_A=ALU_B=0.
  - START=1 and ABORT=0 at an edge: MC<=MCAND, P_LO<=MPLIER, P_HI<=0, CNT<=0, go to RUN.
  - START with ABORT=1: stay in IDLE.
- State RUN (exactly 16 cycles):
  - Combinationally drive ALU_A=P_HI, ALU_B=(P_LO[0] ? MC : 0), ALU_SEL=4'b0000 (ADD).
  - Each edge: {P_HI,P_LO} <= {ALU_FLAG[1], ALU_RES, P_LO[15:1]}, a 33-bit right shift with the ALU carry entering at the top. CNT<=CNT+1.
  - When CNT==15 at the edge: PRODUCT <= the shifted value {ALU_FLAG[1], ALU_RES, P_LO[15:1]}, then go to FIN.
- State FIN (1 cycle): DONE=1, BUSY=1, ALU_SEL=1111; next edge go to IDLE.
- Latency: START sampled at edge 0 → RUN during cycles 1..16 → DONE high in cycle 17 → READY in cycle 18. Throughput is one multiply per 18 cycles.
- START while BUSY=1 is ignored; it is neither queued nor does it alter operands.
- ABORT=1 in RUN or FIN: return to IDLE at the next edge.
  - DONE is not asserted in the following cycle.
  - PRODUCT is unchanged.
  - ALU_SEL returns to 1111.
- ABORT in IDLE has no effect.
- DONE, READY and BUSY are state decodes and glitch-free. PRODUCT changes only on the final RUN edge.
- Arithmetic is unsigned; the result is exact for the full 32-bit range with no overflow. The V and S flags are ignored; only C is used.
- MCAND/MPLIER changes after acceptance have no effect.

Test Plan:
- Reset, then START with MCAND=3, MPLIER=5 → ALU_SEL=0000 for exactly 16 cycles; DONE pulses in cycle 17; PRODUCT=0x0000000F; READY=1 in cycle 18.
- MCAND=0xFFFF, MPLIER=0xFFFF → PRODUCT=0xFFFE0001. The carry path is exercised: ALU_FLAG[1]=1 is observed in RUN.
- MCAND=0x8000, MPLIER=0x0002 → PRODUCT=0x00010000. Then MCAND=0x1234, MPLIER=0 → PRODUCT=0x00000000, and ALU_B=0 in every RUN cycle.
- Start 7x9 (PRODUCT=63); start 0x00FF x 0x0100; assert ABORT in RUN cycle 8 → IDLE next cycle; no DONE; PRODUCT still 63. Also pulse START in RUN cycle 3 with other operands → ignored, result unaffected.
- Deassert RST_N asynchronously in RUN cycle 10 → outputs take reset values without a clock edge. After release, 2x2 completes with PRODUCT=4 at cycle 17.
- Back-to-back: hold START high continuously → operations accepted only in IDLE cycles, spaced exactly 18 cycles apart; ALU_SEL=1111 in every IDLE and FIN cycle.

Source files
------------

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - shift-and-add 16x16->32 unsigned multiplier sequenced over the shared ALU
module alu_mul_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               START,
    input  logic               ABORT,
    input  logic [WIDTH-1:0]   MCAND,
    input  logic [WIDTH-1:0]   MPLIER,
    output logic               READY,
    output logic               BUSY,
    output logic               DONE,
    output logic [2*WIDTH-1:0] PRODUCT,
    output logic [WIDTH-1:0]   ALU_A,
    output logic [WIDTH-1:0]   ALU_B,
    output logic [3:0]         ALU_SEL,
    input  logic [WIDTH-1:0]   ALU_RES,
    input  logic [3:0]         ALU_FLAG
);

    localparam logic [3:0] SEL_ADD  = 4'b0000;
    localparam logic [3:0] SEL_NOP  = 4'b1111;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   p_hi;
    logic [WIDTH-1:0]   p_lo;
    logic [WIDTH-1:0]   mc;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] shifted;
    logic               accept;
    logic               last_step;

    // Only the carry is consumed; sign, zero and overflow are irrelevant to unsigned accumulation.
    logic unused_flags;
    assign unused_flags = ^{ALU_FLAG[3:2], ALU_FLAG[0]};

    // Partial product shifts right one bit with the adder carry entering at the top.
    assign shifted   = {ALU_FLAG[1], ALU_RES, p_lo[WIDTH-1:1]};
    assign accept    = (state == ST_IDLE) && START && !ABORT;
    assign last_step = (state == ST_RUN) && !ABORT && (cnt == CNT_LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        READY     = 1'b0;
        BUSY      = 1'b0;
        DONE      = 1'b0;
        ALU_A     = '0;
        ALU_B     = '0;
        ALU_SEL   = SEL_NOP;
        case (state)
            ST_IDLE: begin
                READY = 1'b1;
                if (accept) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                BUSY    = 1'b1;
                ALU_A   = p_hi;
                ALU_B   = p_lo[0] ? mc : '0;
                ALU_SEL = SEL_ADD;
                if (ABORT) begin
                    state_nxt = ST_IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_FIN;
                end
            end
            ST_FIN: begin
                BUSY      = 1'b1;
                DONE      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            p_hi    <= '0;
            p_lo    <= '0;
            mc      <= '0;
            cnt     <= '0;
            PRODUCT <= '0;
        end else begin
            if (accept) begin
                mc   <= MCAND;
                p_lo <= MPLIER;
                p_hi <= '0;
                cnt  <= '0;
            end else if ((state == ST_RUN) && !ABORT) begin
                {p_hi, p_lo} <= shifted;
                cnt          <= cnt + 1'b1;
            end
            if (last_step) begin
                PRODUCT <= shifted;
            end
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb/tb_alu_mul_seq.sv - randomized self-checking bench for alu_mul_seq with a behavioural ALU
module tb_alu_mul_seq;

    logic        CLK;
    logic        RST_N;
    logic        START;
    logic        ABORT;
    logic [15:0] MCAND;
    logic [15:0] MPLIER;
    logic        READY;
    logic        BUSY;
    logic        DONE;
    logic [31:0] PRODUCT;
    logic [15:0] ALU_A;
    logic [15:0] ALU_B;
    logic [3:0]  ALU_SEL;
    logic [15:0] ALU_RES;
    logic [3:0]  ALU_FLAG;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic        obs_ready [0:20];
    logic        obs_busy  [0:20];
    logic        obs_done  [0:20];
    logic [3:0]  obs_sel   [0:20];
    logic [15:0] obs_b     [0:20];
    logic        obs_carry [0:20];
    logic [31:0] obs_prod  [0:20];

    alu_mul_seq #(.WIDTH(16), .CNT_W(5)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .ABORT(ABORT),
        .MCAND(MCAND), .MPLIER(MPLIER), .READY(READY), .BUSY(BUSY),
        .DONE(DONE), .PRODUCT(PRODUCT), .ALU_A(ALU_A), .ALU_B(ALU_B),
        .ALU_SEL(ALU_SEL), .ALU_RES(ALU_RES), .ALU_FLAG(ALU_FLAG)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural stand-in for the shared ALU: flags ordered {S,Z,C,V}.
    logic [16:0] alu_sum;
    always_comb begin
        case (ALU_SEL)
            4'b0000: alu_sum = {1'b0, ALU_A} + {1'b0, ALU_B};
            4'b0001: alu_sum = {1'b0, ALU_A} - {1'b0, ALU_B};
            default: alu_sum = {1'b0, ALU_A};
        endcase
        ALU_RES  = alu_sum[15:0];
        ALU_FLAG = {alu_sum[15], (alu_sum[15:0] == 16'h0), alu_sum[16], 1'b0};
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issues one multiply and records outputs for cycles 1..20 after acceptance.
    task automatic do_mul(input logic [15:0] a, input logic [15:0] b,
                          input int abort_cyc, input int pulse_cyc);
        @(posedge CLK); #1;
        MCAND = a; MPLIER = b; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0; MCAND = 16'($urandom); MPLIER = 16'($urandom);
        for (int c = 1; c <= 20; c++) begin
            @(negedge CLK);
            obs_ready[c] = READY;
            obs_busy[c]  = BUSY;
            obs_done[c]  = DONE;
            obs_sel[c]   = ALU_SEL;
            obs_b[c]     = ALU_B;
            obs_carry[c] = (ALU_SEL == 4'b0000) && ALU_FLAG[1];
            obs_prod[c]  = PRODUCT;
            START = (c == pulse_cyc);
            ABORT = (c == abort_cyc);
            if (c == pulse_cyc) begin
                MCAND = 16'($urandom); MPLIER = 16'($urandom);
            end
        end
        START = 1'b0; ABORT = 1'b0;
    endtask

    task automatic test_reset;
        total_cnt++; if (READY !== 1'b1) $display("FAIL reset_ready got %b want 1", READY); else pass_cnt++;
        total_cnt++; if (BUSY !== 1'b0) $display("FAIL reset_busy got %b want 0", BUSY); else pass_cnt++;
        total_cnt++; if (DONE !== 1'b0) $display("FAIL reset_done got %b want 0", DONE); else pass_cnt++;
        total_cnt++; if (PRODUCT !== 32'h0) $display("FAIL reset_product got %h want 0", PRODUCT); else pass_cnt++;
        total_cnt++; if (ALU_SEL !== 4'hF) $display("FAIL reset_sel got %h want f", ALU_SEL); else pass_cnt++;
        total_cnt++; if ({ALU_A, ALU_B} !== 32'h0) $display("FAIL reset_alu_ab got %h want 0", {ALU_A, ALU_B}); else pass_cnt++;
    endtask

    task automatic test_basic;
        int n_add;
        int n_done;
        do_mul(16'd3, 16'd5, 0, 0);
        n_add = 0; n_done = 0;
        for (int c = 1; c <= 20; c++) begin
            if (obs_sel[c] == 4'b0000) n_add++;
            if (obs_done[c]) n_done++;
        end
        total_cnt++; if (n_add != 16) $display("FAIL basic_add_cycles got %0d want 16", n_add); else pass_cnt++;
        total_cnt++; if (obs_sel[1] !== 4'b0000 || obs_sel[16] !== 4'b0000 || obs_sel[17] !== 4'hF)
            $display("FAIL basic_add_window got %h/%h/%h want 0/0/f", obs_sel[1], obs_sel[16], obs_sel[17]); else pass_cnt++;
        total_cnt++; if (obs_busy[1] !== 1'b1 || obs_ready[1] !== 1'b0)
            $display("FAIL basic_busy1 got busy=%b ready=%b want 1/0", obs_busy[1], obs_ready[1]); else pass_cnt++;
        total_cnt++; if (obs_done[17] !== 1'b1 || n_done != 1)
            $display("FAIL basic_done got done17=%b count=%0d want 1/1", obs_done[17], n_done); else pass_cnt++;
        total_cnt++; if (obs_prod[16] !== 32'h0) $display("FAIL basic_prod_early got %h want 0", obs_prod[16]); else pass_cnt++;
        total_cnt++; if (obs_prod[17] !== 32'h0000000F) $display("FAIL basic_product got %h want 0000000f", obs_prod[17]); else pass_cnt++;
        total_cnt++; if (obs_ready[18] !== 1'b1 || obs_busy[18] !== 1'b0)
            $display("FAIL basic_ready18 got ready=%b busy=%b want 1/0", obs_ready[18], obs_busy[18]); else pass_cnt++;
    endtask

    task automatic test_corners;
        logic carry_seen;
        logic b_nonzero;
        do_mul(16'hFFFF, 16'hFFFF, 0, 0);
        carry_seen = 1'b0;
        for (int c = 1; c <= 16; c++) carry_seen |= obs_carry[c];
        total_cnt++; if (obs_prod[17] !== 32'hFFFE0001) $display("FAIL max_product got %h want fffe0001", obs_prod[17]); else pass_cnt++;
        total_cnt++; if (carry_seen !== 1'b1) $display("FAIL max_carry got %b want 1", carry_seen); else pass_cnt++;
        do_mul(16'h8000, 16'h0002, 0, 0);
        total_cnt++; if (obs_prod[17] !== 32'h00010000) $display("FAIL msb_product got %h want 00010000", obs_prod[17]); else pass_cnt++;
        do_mul(16'h1234, 16'h0000, 0, 0);
        b_nonzero = 1'b0;
        for (int c = 1; c <= 16; c++) if (obs_b[c] != 16'h0) b_nonzero = 1'b1;
        total_cnt++; if (obs_prod[17] !== 32'h0) $display("FAIL zero_product got %h want 0", obs_prod[17]); else pass_cnt++;
        total_cnt++; if (b_nonzero !== 1'b0) $display("FAIL zero_alu_b got nonzero=%b want 0", b_nonzero); else pass_cnt++;
    endtask

    task automatic test_random;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
        for (int i = 0; i < 12; i++) begin
            a = 16'($urandom); b = 16'($urandom);
            exp = 32'(a) * 32'(b);
            do_mul(a, b, 0, 0);
            total_cnt++; if (obs_prod[17] !== exp || obs_done[17] !== 1'b1)
                $display("FAIL random_%0d %h*%h got %h done=%b want %h done=1", i, a, b, obs_prod[17], obs_done[17], exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_abort_and_ignore;
        int n_done;
        do_mul(16'd7, 16'd9, 0, 0);
        total_cnt++; if (obs_prod[17] !== 32'd63) $display("FAIL abort_setup got %0d want 63", obs_prod[17]); else pass_cnt++;
        do_mul(16'h00FF, 16'h0100, 8, 3);
        n_done = 0;
        for (int c = 1; c <= 20; c++) if (obs_done[c]) n_done++;
        total_cnt++; if (obs_ready[9] !== 1'b1 || obs_sel[9] !== 4'hF)
            $display("FAIL abort_idle got ready=%b sel=%h want 1/f", obs_ready[9], obs_sel[9]); else pass_cnt++;
        total_cnt++; if (obs_busy[8] !== 1'b1) $display("FAIL abort_busy8 got %b want 1", obs_busy[8]); else pass_cnt++;
        total_cnt++; if (n_done != 0) $display("FAIL abort_no_done got %0d want 0", n_done); else pass_cnt++;
        total_cnt++; if (obs_prod[20] !== 32'd63) $display("FAIL abort_product got %0d want 63", obs_prod[20]); else pass_cnt++;
        do_mul(16'h00FF, 16'h0100, 0, 3);
        total_cnt++; if (obs_prod[17] !== 32'h0000FF00 || obs_done[17] !== 1'b1)
            $display("FAIL ignore_start got %h done=%b want 0000ff00 done=1", obs_prod[17], obs_done[17]); else pass_cnt++;
        total_cnt++; if (obs_ready[18] !== 1'b1 || obs_busy[19] !== 1'b0)
            $display("FAIL ignore_requeue got ready18=%b busy19=%b want 1/0", obs_ready[18], obs_busy[19]); else pass_cnt++;
    endtask

    task automatic test_async_reset;
        @(posedge CLK); #1;
        MCAND = 16'h1234; MPLIER = 16'h5678; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (10) @(negedge CLK);
        total_cnt++; if (BUSY !== 1'b1 || ALU_SEL !== 4'b0000)
            $display("FAIL rst_pre got busy=%b sel=%h want 1/0", BUSY, ALU_SEL); else pass_cnt++;
        #2 RST_N = 1'b0;
        #1;
        total_cnt++; if (READY !== 1'b1 || BUSY !== 1'b0 || DONE !== 1'b0)
            $display("FAIL rst_async_state got r=%b b=%b d=%b want 1/0/0", READY, BUSY, DONE); else pass_cnt++;
        total_cnt++; if (PRODUCT !== 32'h0 || ALU_SEL !== 4'hF || {ALU_A, ALU_B} !== 32'h0)
            $display("FAIL rst_async_out got prod=%h sel=%h ab=%h want 0/f/0", PRODUCT, ALU_SEL, {ALU_A, ALU_B}); else pass_cnt++;
        @(negedge CLK);
        RST_N = 1'b1;
        do_mul(16'd2, 16'd2, 0, 0);
        total_cnt++; if (obs_prod[17] !== 32'd4 || obs_done[17] !== 1'b1)
            $display("FAIL rst_recover got %0d done=%b want 4 done=1", obs_prod[17], obs_done[17]); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_q[$];
        logic [31:0] exp;
        int last_acc;
        int last_done;
        int n_acc;
        int n_done;
        last_acc = -1; last_done = -1; n_acc = 0; n_done = 0;
        @(negedge CLK);
        for (int c = 0; c < 78; c++) begin
            if ((READY || DONE) && ALU_SEL !== 4'hF) begin
                total_cnt++;
                $display("FAIL b2b_sel_idle cycle %0d got %h want f", c, ALU_SEL);
            end
            if (DONE) begin
                n_done++;
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
                total_cnt++; if (PRODUCT !== exp) $display("FAIL b2b_product cycle %0d got %h want %h", c, PRODUCT, exp); else pass_cnt++;
                if (last_done >= 0) begin
                    total_cnt++; if (c - last_done != 18) $display("FAIL b2b_done_spacing got %0d want 18", c - last_done); else pass_cnt++;
                end
                last_done = c;
            end
            START = (c < 60);
            MCAND = 16'($urandom); MPLIER = 16'($urandom);
            if (READY && START) begin
                n_acc++;
                exp_q.push_back(32'(MCAND) * 32'(MPLIER));
                if (last_acc >= 0) begin
                    total_cnt++; if (c - last_acc != 18) $display("FAIL b2b_accept_spacing got %0d want 18", c - last_acc); else pass_cnt++;
                end
                last_acc = c;
            end
            @(negedge CLK);
        end
        START = 1'b0;
        total_cnt++; if (n_acc != 4 || n_done != 4)
            $display("FAIL b2b_counts got acc=%0d done=%0d want 4/4", n_acc, n_done); else pass_cnt++;
    endtask

    initial begin
        RST_N = 1'b0; START = 1'b0; ABORT = 1'b0; MCAND = '0; MPLIER = '0;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        test_reset();
        test_basic();
        test_corners();
        test_random();
        test_abort_and_ignore();
        test_async_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
